// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings and decode helpers for the EX-stage RV32M multiply/divide unit.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  // MULHSU treats rs2 as unsigned, so only rs1 carries a sign for it.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
           (op == MULDIV_DIV)  || (op == MULDIV_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift register datapath: shift-add multiply and restoring divide on magnitudes.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  // hi: product high half / partial remainder; lo: multiplier / dividend-quotient; b: addend / divisor
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    // shifted < 2*divisor always, so bit XLEN of the difference is exactly the borrow.
    diff    = shifted - {1'b0, b_q};

    if (load) begin
      hi_d = '0;
      lo_d = is_div ? a_mag : b_mag;
      b_d  = is_div ? b_mag : a_mag;
    end else if (step) begin
      if (is_div) begin
        if (!diff[XLEN]) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = add_sum[XLEN:1];
        lo_d = {add_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end

  assign product   = {hi_q, lo_q};
  assign quotient  = lo_q;
  assign remainder = hi_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M unit: FSM, iteration counter, special-case bypass, sign fix-up and stall.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_e      op_q, op_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  muldiv_op_e      op_in;
  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  logic            div_by_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            accept, dp_is_div;

  logic [2*XLEN-1:0] product, prod_fix;
  logic [XLEN-1:0]   quotient, remainder, quo_fix, rem_fix, fix_res;

  always_comb begin
    op_in       = muldiv_op_e'(funct3);
    a_neg_in    = op_a_signed(op_in) & rs1_data[XLEN-1];
    b_neg_in    = op_b_signed(op_in) & rs2_data[XLEN-1];
    a_mag_in    = a_neg_in ? -rs1_data : rs1_data;
    b_mag_in    = b_neg_in ? -rs2_data : rs2_data;
    div_by_zero = op_is_div(op_in) && (rs2_data == '0);
    div_ovf     = ((op_in == MULDIV_DIV) || (op_in == MULDIV_REM)) &&
                  (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    special     = div_by_zero | div_ovf;
    if (div_by_zero) special_res = op_is_rem(op_in) ? rs1_data : '1;
    else             special_res = op_is_rem(op_in) ? '0 : rs1_data;
    accept      = (state_q == IDLE) && start && !flush;
    dp_is_div   = (state_q == IDLE) ? op_is_div(op_in) : op_is_div(op_q);
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      ((state_q == CALC) && !flush),
    .is_div    (dp_is_div),
    .a_mag     (a_mag_in),
    .b_mag     (b_mag_in),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Remainder follows the dividend's sign; product and quotient follow the sign mismatch.
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -product : product;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -quotient : quotient;
    rem_fix  = neg_a_q ? -remainder : remainder;
    fix_res  = '0;
    case (op_q)
      MULDIV_MUL:                             fix_res = prod_fix[XLEN-1:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MULDIV_DIV, MULDIV_DIVU:                fix_res = quo_fix;
      MULDIV_REM, MULDIV_REMU:                fix_res = rem_fix;
      default:                                fix_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op_in;
          neg_a_d = a_neg_in;
          neg_b_d = b_neg_in;
          cnt_d   = '0;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          result_d = fix_res;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= MULDIV_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // A flush releases the upstream stages in the same cycle it arrives.
  assign stall_req = !flush && ((state_q == CALC) || (state_q == FIX) ||
                                ((state_q == IDLE) && start));
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed plan cases plus randomized ops against an arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        stall_req, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: RISC-V M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drives one op from IDLE; lat = edges from the start edge to the done cycle (-1 on timeout).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_ok, output bit pulse_ok);
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
    #1;
    stall_ok = (stall_req === 1'b1);
    pulse_ok = 1'b1;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        lat = c;
        if (stall_req !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall_req !== 1'b1) stall_ok = 1'b0;
    end
    res = result;
    @(posedge clk); #1;
    if (done !== 1'b0 || result !== res) pulse_ok = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (result !== 32'h0 || done !== 1'b0 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: result=%h done=%b stall=%b, wanted 0/0/0", result, done, stall_req);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_mul_latency();
    logic [31:0] res; int lat; bit s_ok, p_ok;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, s_ok, p_ok);
    total++;
    if (res !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    total++;
    if (lat !== 34) begin bad++; $display("FAIL mul_latency: got %0d want 34", lat); end
    total++;
    if (!s_ok) begin bad++; $display("FAIL mul_stall: stall_req not high in cycles 0..33 / low on done"); end
    total++;
    if (!p_ok) begin bad++; $display("FAIL mul_pulse: done not a single-cycle pulse or result not held"); end
  endtask

  task automatic test_mul_high();
    logic [2:0]  ops [3] = '{3'd3, 3'd1, 3'd2};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] res; int lat; bit s_ok, p_ok;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, s_ok, p_ok);
      total++;
      if (res !== exp[i] || lat !== 34) begin
        bad++;
        $display("FAIL mul_high f=%0d: got %h lat=%0d want %h lat=34", ops[i], res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_div_signs();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
    logic [31:0] res; int lat; bit s_ok, p_ok;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFF_FFF9, 32'd2, res, lat, s_ok, p_ok);
      total++;
      if (res !== exp[i] || lat !== 34) begin
        bad++;
        $display("FAIL div_signs f=%0d: got %h lat=%0d want %h lat=34", ops[i], res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    logic [31:0] res; int lat; bit s_ok, p_ok;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, s_ok, p_ok);
      total++;
      if (res !== exp[i] || lat !== 1 || !s_ok || !p_ok) begin
        bad++;
        $display("FAIL special f=%0d: got %h lat=%0d stall_ok=%b pulse_ok=%b want %h lat=1",
                 ops[i], res, lat, s_ok, p_ok, exp[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res; int lat; bit s_ok, p_ok; bit saw_done;
    prev = result;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) saw_done = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (saw_done || done !== 1'b0 || stall_req !== 1'b0 || result !== prev) begin
      bad++;
      $display("FAIL flush_abort: done=%b early_done=%b stall=%b result=%h want 0/0/0/%h",
               done, saw_done, stall_req, result, prev);
    end
    run_op(3'd5, 32'd100, 32'd7, res, lat, s_ok, p_ok);
    total++;
    if (res !== 32'd14 || lat !== 34) begin
      bad++;
      $display("FAIL flush_restart: got %h lat=%0d want 0000000e lat=34", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat; bit s_ok, p_ok;
    logic [2:0]  ops [3] = '{3'd1, 3'd7, 3'd0};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'd1000, 32'h1234_5678};
    logic [31:0] bs  [3] = '{32'h8000_0000, 32'd33, 32'h9ABC_DEF0};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, s_ok, p_ok);
      total++;
      if (res !== ref_model(ops[i], as[i], bs[i]) || lat !== 34 || !s_ok) begin
        bad++;
        $display("FAIL back_to_back f=%0d: got %h lat=%0d want %h lat=34",
                 ops[i], res, lat, ref_model(ops[i], as[i], bs[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b; logic [2:0] f; int lat; bit s_ok, p_ok;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(f, a, b, res, lat, s_ok, p_ok);
      total++;
      if (res !== ref_model(f, a, b) || lat !== ref_latency(f, a, b) || !s_ok || !p_ok) begin
        bad++;
        $display("FAIL random f=%0d a=%h b=%h: got %h lat=%0d stall_ok=%b pulse_ok=%b want %h lat=%0d",
                 f, a, b, res, lat, s_ok, p_ok, ref_model(f, a, b), ref_latency(f, a, b));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; int lat; bit s_ok, p_ok;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'h1234; rs2_data = 32'h5678;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (result !== 32'h0 || done !== 1'b0 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: result=%h done=%b stall=%b want 0/0/0", result, done, stall_req);
    end
    @(negedge clk) rst = 1'b1;
    run_op(3'd0, 32'd3, 32'd4, res, lat, s_ok, p_ok);
    total++;
    if (res !== 32'd12 || lat !== 34) begin
      bad++;
      $display("FAIL post_reset_mul: got %h lat=%0d want 0000000c lat=34", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_mul_high();
    test_div_signs();
    test_special();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the rs1/rs2 operand words and funct3 latched by ID/EX.
- Raises stall_req back to the hazard logic, so ID/EX inserts bubbles and IF/ID holds while an operation runs.
- Delivers a 32-bit result with a one-cycle done pulse to the EX/MEM write-back mux.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  M-extension instruction valid in EX (from ID/EX decode)
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data  input  XLEN  operand A (dividend / multiplicand)
- rs2_data  input  XLEN  operand B (divisor / multiplier)
- flush  input  1  jb flush; aborts any operation in progress
- stall_req  output  1  freeze the upstream stages
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  operation result, held until the next start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, all internal registers 0. Outputs: result=0, done=0, stall_req=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 at a clock edge latches funct3 and the operands.
  - Signed ops (MULH, MULHSU, DIV, REM) latch operand magnitudes plus sign flags. MULHSU treats rs2 as unsigned.
  - Next state is CALC, or DONE directly for a special case.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2*XLEN accumulator.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- CALC runs exactly XLEN cycles; counter counts 0..XLEN-1, then the FSM moves to FIX.
- FIX (one cycle):
  - Apply sign correction. Product is negated if the operand signs differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Select the field: MUL gives the low XLEN bits; MULH/MULHSU/MULHU give the high XLEN bits; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Register result.
- DONE (one cycle): done=1, next state IDLE.
- Latency:
  - Normal operation: done is high in cycle XLEN+2 after the start edge (34 for XLEN=32).
  - Special case: done is high 1 cycle after the start edge.
- Special cases are resolved at start, skip CALC/FIX, and write result directly:
  - Divisor 0: DIV and DIVU give all-ones; REM and REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- stall_req = (state==CALC) | (state==FIX) | (state==IDLE & start & ~flush). It is combinational and low in DONE, so the consuming instruction advances on the done cycle.
- flush=1 in CALC or FIX: next state IDLE; no done pulse; result keeps its old value; stall_req drops the same cycle.
- flush in DONE: done still pulses; the downstream register discards it.
- start during CALC/FIX/DONE is ignored, since upstream is stalled.
- Arithmetic is unsigned internally on XLEN+1-bit partial remainders. There is no saturation; all results wrap modulo 2^XLEN.

Decomposition:
- Shared package holds the funct3 encodings (MULDIV_MUL ... MULDIV_REMU) and the state encoding localparams (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3).
- One natural sub-module, muldiv_datapath: accumulator/remainder shift registers plus add/subtract.
- The FSM, counter, special-case detection and stall logic stay in ex_muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result=0xFFFFFFEB; done exactly 34 cycles after the start edge; stall_req high for cycles 0..33.
- rs1=rs2=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
- rs1=0xFFFFFFF9 (-7), rs2=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC; REMU -> 1.
- Special cases, each with done 1 cycle after start:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- flush at CALC cycle 10 -> state IDLE next cycle, no done pulse, stall_req=0. A new DIVU 100/7 started the next cycle -> 14 after 34 cycles.
- rst driven to 0 mid-CALC, asynchronously between edges -> result=0, done=0, stall_req=0 immediately. After release, MUL 3*4 -> 12.
